// File: rtl/out_wrapper_if.sv
// Handshake bundle between the FP multiplier core, the output wrapper and the
// downstream consumer. The wrapper takes the slave view.
interface out_wrapper_if;
  logic        doneFP;
  logic        resultAccept;
  logic [31:0] FPoutBus;
  logic [31:0] outBus;
  logic        resultReady;

  modport master (
    output doneFP,
    output resultAccept,
    output FPoutBus,
    input  outBus,
    input  resultReady
  );

  modport slave (
    input  doneFP,
    input  resultAccept,
    input  FPoutBus,
    output outBus,
    output resultReady
  );
endinterface

// File: rtl/out_wrapper.sv
// Output-side handshake wrapper for the FP multiplier: captures a finished
// result, holds it stable and flags it until a four-phase accept completes.
module out_wrapper (
  input  logic          clk,
  input  logic          rst,
  out_wrapper_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    READY   = 2'b01,
    RELEASE = 2'b10
  } state_t;

  state_t      state;
  logic        ready_q;
  logic [31:0] out_q;
  logic        load;

  // Capture strobe to the datapath: only IDLE may accept a new word.
  assign load = (state == IDLE) && bus.doneFP;

  // Controller: state and the Moore ready flag share one register stage.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values and simulation order between always blocks is irrelevant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ready_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.doneFP) begin
            state   <= READY;
            ready_q <= 1'b1;
          end
        end
        READY: begin
          if (bus.resultAccept) begin
            state   <= RELEASE;
            ready_q <= 1'b0;
          end
        end
        RELEASE: begin
          if (!bus.resultAccept) begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: the result register only changes on reset or a capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= 32'h0000_0000;
    end else if (load) begin
      out_q <= bus.FPoutBus;
    end
  end

  assign bus.outBus      = out_q;
  assign bus.resultReady = ready_q;

endmodule

// File: tb/tb_out_wrapper.sv
// Scoreboard bench for out_wrapper: expected words are queued when a capture
// is driven and popped when resultReady presents them.
module tb_out_wrapper;

  logic clk;
  logic rst;
  out_wrapper_if bus ();

  out_wrapper dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cycle  = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_word;

  always @(posedge clk) cycle++;

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_out(input string name, input logic [31:0] exp_bus,
                           input logic exp_ready);
    checks++;
    if (bus.outBus !== exp_bus || bus.resultReady !== exp_ready) begin
      errors++;
      $display("FAIL %s: got outBus=%h resultReady=%b, expected outBus=%h resultReady=%b",
               name, bus.outBus, bus.resultReady, exp_bus, exp_ready);
    end
  endtask

  task automatic expect_capture(input string name);
    logic [31:0] exp;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got outBus=%h resultReady=%b",
               name, bus.outBus, bus.resultReady);
    end else begin
      exp = sb_q.pop_front();
      last_word = exp;
      if (bus.outBus !== exp || bus.resultReady !== 1'b1) begin
        errors++;
        $display("FAIL %s: got outBus=%h resultReady=%b, expected outBus=%h resultReady=1",
                 name, bus.outBus, bus.resultReady, exp);
      end
    end
  endtask

  // Full accept handshake from READY; leaves the FSM in IDLE.
  task automatic handshake(input string name);
    bus.resultAccept = 1'b1;
    step();
    check_out({name, "_accept"}, last_word, 1'b0);
    bus.resultAccept = 1'b0;
    step();
    check_out({name, "_release"}, last_word, 1'b0);
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    bus.doneFP       = 1'b1;
    bus.resultAccept = 1'b0;
    bus.FPoutBus     = 32'hFFFF_FFFF;
    step();
    check_out("reset_c1", 32'h0, 1'b0);
    step();
    check_out("reset_c2", 32'h0, 1'b0);
    rst = 1'b0;
    sb_q.push_back(32'hFFFF_FFFF);
    step();
    bus.doneFP = 1'b0;
    expect_capture("reset_first_capture");
    handshake("reset_hs");
  endtask

  task automatic test_basic_capture();
    bus.FPoutBus = 32'h42FA_4000;
    bus.doneFP   = 1'b1;
    sb_q.push_back(32'h42FA_4000);
    step();
    bus.doneFP = 1'b0;
    expect_capture("basic_capture");
    for (int i = 0; i < 10; i++) begin
      step();
      check_out("basic_hold", last_word, 1'b1);
    end
  endtask

  task automatic test_bus_change_ready();
    bus.FPoutBus = 32'h3F80_0000;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("bus_change_ready", 32'h42FA_4000, 1'b1);
    end
  endtask

  task automatic test_handshake();
    bus.resultAccept = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) bus.FPoutBus = 32'hDEAD_BEEF;
      step();
      check_out("hs_accept_high", 32'h42FA_4000, 1'b0);
    end
    bus.resultAccept = 1'b0;
    step();
    check_out("hs_release", 32'h42FA_4000, 1'b0);
    // IDLE reached: the very next edge must capture.
    bus.FPoutBus = 32'h1234_5678;
    bus.doneFP   = 1'b1;
    sb_q.push_back(32'h1234_5678);
    step();
    bus.doneFP = 1'b0;
    expect_capture("hs_next_capture");
    handshake("hs_done");
  endtask

  task automatic test_held_done();
    int first_rise;
    int period;
    bus.FPoutBus = 32'h3F80_0000;
    bus.doneFP   = 1'b1;
    sb_q.push_back(32'h3F80_0000);
    step();
    expect_capture("held_first");
    first_rise = cycle;
    bus.resultAccept = 1'b1;
    step();
    check_out("held_accept", 32'h3F80_0000, 1'b0);
    bus.resultAccept = 1'b0;
    sb_q.push_back(32'h3F80_0000);
    step();
    check_out("held_release", 32'h3F80_0000, 1'b0);
    period = 0;
    for (int i = 0; i < 8 && bus.resultReady !== 1'b1; i++) step();
    period = cycle - first_rise;
    expect_capture("held_recapture");
    checks++;
    if (period != 3) begin
      errors++;
      $display("FAIL held_period: got %0d cycles, expected 3", period);
    end
    bus.doneFP = 1'b0;
    handshake("held_hs");
  endtask

  task automatic test_reset_mid();
    bus.FPoutBus = 32'hA5A5_0F0F;
    bus.doneFP   = 1'b1;
    sb_q.push_back(32'hA5A5_0F0F);
    step();
    bus.doneFP = 1'b0;
    expect_capture("mid_capture");
    bus.resultAccept = 1'b1;
    step();
    check_out("mid_release", 32'hA5A5_0F0F, 1'b0);
    rst = 1'b1;
    step();
    check_out("mid_reset", 32'h0, 1'b0);
    rst = 1'b0;
    // accept still high in IDLE: capture must win.
    bus.FPoutBus = 32'hC0DE_0001;
    bus.doneFP   = 1'b1;
    sb_q.push_back(32'hC0DE_0001);
    step();
    bus.doneFP = 1'b0;
    expect_capture("mid_capture_with_accept");
    step();
    check_out("mid_accept_in_ready", 32'hC0DE_0001, 1'b0);
    bus.resultAccept = 1'b0;
    step();
    check_out("mid_back_idle", 32'hC0DE_0001, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    for (int i = 0; i < 4; i++) begin
      v = $urandom();
      bus.FPoutBus = v;
      bus.doneFP   = 1'b1;
      sb_q.push_back(v);
      step();
      bus.doneFP = 1'b0;
      bus.FPoutBus = ~v;
      expect_capture("b2b_capture");
      handshake("b2b_hs");
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
  endtask

  initial begin
    last_word = 32'h0;
    test_reset();
    test_basic_capture();
    test_bus_change_ready();
    test_handshake();
    test_held_done();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
